// File: rtl/fp32_operand_loader.sv
// Byte-serial operand loader: assembles operand A then operand B from
// bytes on byte_in, then presents both to the FP32 multiplier behind a
// valid/ready handshake.

// One byte lane of both operands; written on a selected accept, zeroed by clear.
module op_byte_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       wr_a,
  input  logic       wr_b,
  input  logic [7:0] din,
  output logic [7:0] a_byte,
  output logic [7:0] b_byte
);

  // Lane storage: clear wins over writes; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_byte <= '0;
      b_byte <= '0;
    end else if (clear) begin
      a_byte <= '0;
      b_byte <= '0;
    end else begin
      if (wr_a) a_byte <= din;
      if (wr_b) b_byte <= din;
    end
  end

endmodule

module fp32_operand_loader #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [3:0]       load_count,
  output logic [1:0]       phase
);

  localparam int BYTES = WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   pos;
  logic            rdy_en;
  logic            accept;
  logic            last;
  logic            handover;

  logic [BYTES-1:0][7:0] a_lane;
  logic [BYTES-1:0][7:0] b_lane;

  // rdy_en keeps byte_ready low while in reset and until the first edge after release.
  assign byte_ready = rdy_en && (state != PRESENT);
  assign accept     = byte_valid && byte_ready && !clear;
  assign last       = (cnt == CW'(BYTES - 1));
  assign handover   = op_valid && op_ready && !clear;
  assign pos        = MSB_FIRST ? (CW'(BYTES - 1) - cnt) : cnt;
  assign phase      = state;
  assign op_a       = a_lane;
  assign op_b       = b_lane;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nxt;
  end

  // Next state: clear forces LOAD_A ahead of any accept or handover.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = LOAD_A;
    end else begin
      unique case (state)
        LOAD_A:  if (accept && last) state_nxt = LOAD_B;
        LOAD_B:  if (accept && last) state_nxt = PRESENT;
        PRESENT: if (handover)       state_nxt = LOAD_A;
        default:                     state_nxt = LOAD_A;
      endcase
    end
  end

  // Byte index, transaction byte count and the registered op_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en     <= 1'b0;
      cnt        <= '0;
      load_count <= '0;
      op_valid   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (clear) begin
        cnt        <= '0;
        load_count <= '0;
        op_valid   <= 1'b0;
      end else begin
        op_valid <= (state_nxt == PRESENT);
        if (accept) begin
          cnt        <= last ? '0 : cnt + CW'(1);
          load_count <= load_count + 4'd1;
        end else if (handover) begin
          load_count <= '0;
        end
      end
    end
  end

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    op_byte_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .wr_a   (accept && (state == LOAD_A) && (pos == CW'(i))),
      .wr_b   (accept && (state == LOAD_B) && (pos == CW'(i))),
      .din    (byte_in),
      .a_byte (a_lane[i]),
      .b_byte (b_lane[i])
    );
  end

endmodule

// File: tb/tb_fp32_operand_loader.sv
// Bench for fp32_operand_loader: directed scenarios plus random traffic,
// every cycle compared against a byte-queue model of the transaction.
module tb_fp32_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        clear;
  logic [31:0] op_a, op_b;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  load_count;
  logic [1:0]  phase;

  int n_vec = 0;
  int n_err = 0;

  // Model: bytes accepted in the current transaction, plus the retained
  // operand bytes in arrival order (arrival 0 is the most significant).
  logic [7:0] q[$];
  logic [7:0] ea[4];
  logic [7:0] eb[4];
  bit         ready_en_m;

  fp32_operand_loader #(.WIDTH(32), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .clear      (clear),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .load_count (load_count),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      ea[i] = 8'h00;
      eb[i] = 8'h00;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".byte_ready"}, {31'd0, byte_ready}, {31'd0, ready_en_m && (n < 8)});
    chk({tag, ".phase"},      {30'd0, phase},      n / 4);
    chk({tag, ".load_count"}, {28'd0, load_count}, n);
    chk({tag, ".op_valid"},   {31'd0, op_valid},   {31'd0, n == 8});
    chk({tag, ".op_a"},       op_a,                {ea[0], ea[1], ea[2], ea[3]});
    chk({tag, ".op_b"},       op_b,                {eb[0], eb[1], eb[2], eb[3]});
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input string tag, input logic bv, input logic [7:0] b,
                     input logic rdy, input logic clr);
    bit acc, ho;
    int k;
    byte_valid = bv;
    byte_in    = b;
    op_ready   = rdy;
    clear      = clr;
    acc = ready_en_m && (q.size() < 8) && bv && !clr;
    ho  = !clr && (q.size() == 8) && rdy;
    @(posedge clk);
    #1;
    if (clr) begin
      model_zero();
    end else if (acc) begin
      k = q.size();
      if (k < 4) ea[k] = b;
      else       eb[k - 4] = b;
      q.push_back(b);
    end else if (ho) begin
      q.delete();
    end
    ready_en_m = 1'b1;
    check_all(tag);
  endtask

  // Offer one byte repeatedly until the model says it was taken (bounded).
  task automatic send(input string tag, input logic [7:0] b);
    for (int t = 0; t < 20; t++) begin
      if (ready_en_m && q.size() < 8) begin
        cyc(tag, 1'b1, b, 1'b1, 1'b0);
        return;
      end
      cyc(tag, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk({tag, ".send_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    logic [7:0] basic[8];
    logic [7:0] fullp[8];
    bit         gaps[10];
    int         gi;

    basic = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
    fullp = '{8'h3F, 8'hC0, 8'h00, 8'h00, 8'hC0, 8'h49, 8'h0F, 8'hDB};
    gaps  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; clear = 1'b0; op_ready = 1'b0;
    ready_en_m = 1'b0;
    model_zero();

    // Reset state, held across clock edges.
    #22;
    check_all("reset");
    #1 rst_n = 1'b1;
    cyc("post_reset", 1'b0, 8'h00, 1'b1, 1'b0);

    // Basic load, continuous valid, op_ready high; one cycle of op_valid.
    for (int i = 0; i < 8; i++) cyc("basic", 1'b1, basic[i], 1'b1, 1'b0);
    chk("basic.op_a_value", op_a, 32'h40000000);
    chk("basic.op_b_value", op_b, 32'h40000000);
    cyc("basic.handover", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("basic.idle", 1'b0, 8'h00, 1'b1, 1'b0);

    // Full-precision operands with gapped valid.
    gi = 0;
    for (int i = 0; i < 8; i++) begin
      while (!gaps[gi % 10]) begin
        cyc("gapped.gap", 1'b0, 8'h55, 1'b0, 1'b0);
        gi++;
      end
      cyc("gapped", 1'b1, fullp[i], 1'b0, 1'b0);
      gi++;
    end
    chk("gapped.op_a_value", op_a, 32'h3FC00000);
    chk("gapped.op_b_value", op_b, 32'hC0490FDB);

    // Backpressure: six cycles stalled with FF offered, then release.
    for (int i = 0; i < 6; i++) cyc("bp.stall", 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("bp.op_a_held", op_a, 32'h3FC00000);
    chk("bp.op_b_held", op_b, 32'hC0490FDB);
    cyc("bp.handover", 1'b1, 8'hFF, 1'b1, 1'b0);
    cyc("bp.first_a", 1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) cyc("bp.reload", 1'b1, 8'h11 * i[7:0], 1'b1, 1'b0);
    cyc("bp.done", 1'b0, 8'h00, 1'b1, 1'b0);

    // clear after 5 accepted bytes, raised together with byte_valid.
    for (int i = 0; i < 5; i++) cyc("clr.load", 1'b1, 8'hA0 + i[7:0], 1'b1, 1'b0);
    cyc("clr.abort", 1'b1, 8'hEE, 1'b1, 1'b1);
    chk("clr.op_a_zero", op_a, 32'h0);
    for (int i = 0; i < 8; i++) cyc("clr.reload", 1'b1, basic[7 - i] ^ 8'h3C, 1'b1, 1'b0);
    cyc("clr.done", 1'b0, 8'h00, 1'b1, 1'b0);

    // Async reset in the middle of LOAD_B, away from any clock edge.
    for (int i = 0; i < 6; i++) cyc("arst.load", 1'b1, fullp[i], 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    ready_en_m = 1'b0;
    model_zero();
    check_all("arst.async");
    #2 rst_n = 1'b1;
    cyc("arst.release", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc("arst.reload", 1'b1, fullp[i], 1'b1, 1'b0);
    chk("arst.op_b_value", op_b, 32'hC0490FDB);
    cyc("arst.done", 1'b0, 8'h00, 1'b1, 1'b0);

    // Back-to-back: three random transactions, valid and op_ready always high.
    for (int t = 0; t < 3; t++)
      for (int c = 0; c < 9; c++) cyc("b2b", 1'b1, 8'($urandom), 1'b1, 1'b0);

    // Random traffic with occasional clears and stalls.
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
          ($urandom % 40) == 0);

    // Random bytes through send() for a final complete transaction.
    cyc("tail.clear", 1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send("tail", 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
